// File: rtl/cfg_seq_master_pkg.sv
// Shared definitions for the configuration bring-up master:
// FSM state encoding, register sub-addresses and the rate word width.
// The sub-addresses mirror the register-address include of the configuration block.
package cfg_seq_master_pkg;

    localparam int          RATE_W    = 3;
    localparam logic [15:0] DONE_SUB  = 16'h0080;
    localparam logic [15:0] READY_SUB = 16'h0084;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POLL  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READY = 3'd3,
        ST_RUN   = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

endpackage

// File: rtl/cfg_seq_master_if.sv
// Wishbone bus between one bring-up master and its configuration slave port.
interface cfg_seq_master_if;

    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_ack;
    logic        i_wb_err;

    modport master (
        output o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport slave (
        input  o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
        output i_wb_dat, i_wb_ack, i_wb_err
    );

endinterface

// File: rtl/cfg_seq_master_wb_port.sv
// Single-transfer Wishbone master: one blocking transfer per request,
// enforced idle spacing between transfers, bus error reporting.
// Optional ack timeout enabled by macro CFG_SEQ_TIMEOUT_EN.
module cfg_seq_wb_port
    import cfg_seq_master_pkg::*;
#(
    parameter logic [15:0] ADR_HI   = 16'h0000,
    parameter int          IDLE_GAP = 3,
    parameter int          TO_CYC   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [15:0]       adr_i,
    output logic              done_o,
    output logic [RATE_W-1:0] rdata_o,
    output logic              err_o,
    cfg_seq_master_if.master  wb
);

    localparam int GAP_W = $clog2(IDLE_GAP + 1);

    logic             stb_q;
    logic             we_q;
    logic [15:0]      adr_q;
    logic [GAP_W-1:0] gap_q;
    logic             timeout;
    logic             accept;
    logic             unused_dat;

`ifdef CFG_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Count cycles the current strobe has waited for an acknowledge
    always_ff @(posedge clk) begin
        if (reset || !stb_q) to_cnt_q <= '0;
        else                 to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    assign timeout = stb_q && !wb.i_wb_ack && (to_cnt_q == TO_W'(TO_CYC - 1));
`else
    localparam int unused_to_cyc = TO_CYC;
    assign timeout = 1'b0;
`endif

    assign accept  = req_i && !stb_q && (gap_q == '0);
    assign done_o  = stb_q && wb.i_wb_ack && !wb.i_wb_err;
    assign err_o   = stb_q && (wb.i_wb_err || timeout);
    assign rdata_o = wb.i_wb_dat[RATE_W-1:0];
    assign unused_dat = ^wb.i_wb_dat[31:RATE_W];

    assign wb.o_wb_adr = {ADR_HI, adr_q};
    assign wb.o_wb_sel = stb_q ? 4'hF : 4'h0;
    assign wb.o_wb_we  = stb_q && we_q;
    assign wb.o_wb_dat = 32'h0;
    assign wb.o_wb_cyc = stb_q;
    assign wb.o_wb_stb = stb_q;

    // Launch, hold and terminate one transfer, then keep the bus idle for the gap
    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            gap_q <= GAP_W'(IDLE_GAP - 1);
        end else if (stb_q) begin
            if (done_o || err_o) begin
                stb_q <= 1'b0;
                gap_q <= GAP_W'(IDLE_GAP - 1);
            end
        end else if (accept) begin
            stb_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
        end else if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
        end
    end

endmodule

// File: rtl/cfg_seq_master.sv
// Configuration bring-up master for one ADPCM core side: polls config-done,
// loads the per-channel rate shadow table, writes core-ready, then streams
// (channel, rate) beats on every frame sync.
// Optional ack timeout in the bus port enabled by macro CFG_SEQ_TIMEOUT_EN.
module cfg_seq_master
    import cfg_seq_master_pkg::*;
#(
    parameter int          NUM_CH    = 32,
    parameter logic [15:0] ADR_HI    = 16'h0000,
    parameter logic [15:0] DONE_ADR  = DONE_SUB,
    parameter logic [15:0] READY_ADR = READY_SUB,
    parameter int          POLL_GAP  = 16,
    parameter int          IDLE_GAP  = 3,
    parameter int          TO_CYC    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      reload,
    input  logic                      frame_sync,
    cfg_seq_master_if.master          wb,
    output logic [$clog2(NUM_CH)-1:0] ch_idx,
    output logic [RATE_W-1:0]         ch_rate,
    output logic                      ch_valid,
    output logic                      cfg_loaded,
    output logic                      overrun,
    output logic                      fault
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int PW    = $clog2(POLL_GAP + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  n_q;
    logic [PW-1:0]     poll_wait_q;
    logic [RATE_W-1:0] shadow_q [NUM_CH];
    logic              sweep_act_q;
    logic [IDX_W-1:0]  sweep_idx_q;
    logic              reload_pend_q;
    logic              cfg_loaded_q;
    logic              overrun_q;
    logic              fault_q;

    logic              port_req, port_we, port_done, port_err;
    logic [15:0]       port_adr;
    logic [RATE_W-1:0] port_rdata;
    logic              n_last, sweep_last, sweep_start, go_poll;

    cfg_seq_wb_port #(
        .ADR_HI   (ADR_HI),
        .IDLE_GAP (IDLE_GAP),
        .TO_CYC   (TO_CYC)
    ) u_port (
        .clk     (clk),
        .reset   (reset),
        .req_i   (port_req),
        .we_i    (port_we),
        .adr_i   (port_adr),
        .done_o  (port_done),
        .rdata_o (port_rdata),
        .err_o   (port_err),
        .wb      (wb)
    );

    assign n_last      = (n_q == IDX_W'(NUM_CH - 1));
    assign sweep_last  = sweep_act_q && (sweep_idx_q == IDX_W'(NUM_CH - 1));
    // A pending reload wins over a new frame; a fresh reload coincident with a frame waits for that sweep
    assign go_poll     = sweep_act_q ? (sweep_last && (reload_pend_q || reload))
                                     : (reload_pend_q || (reload && !frame_sync));
    assign sweep_start = frame_sync && !sweep_act_q && !reload_pend_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_POLL;
            ST_POLL:  if (port_err) state_d = ST_HALT;
                      else if (port_done && port_rdata[0]) state_d = ST_LOAD;
            ST_LOAD:  if (port_err) state_d = ST_HALT;
                      else if (port_done && n_last) state_d = ST_READY;
            ST_READY: if (port_err) state_d = ST_HALT;
                      else if (port_done) state_d = ST_RUN;
            ST_RUN:   if (go_poll) state_d = ST_POLL;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus request and stream outputs decoded from state
    always_comb begin
        port_req = 1'b0;
        port_we  = 1'b0;
        port_adr = DONE_ADR;
        case (state_q)
            ST_POLL:  port_req = (poll_wait_q == '0);
            ST_LOAD: begin
                port_req = 1'b1;
                port_adr = 16'({n_q, 2'b00});
            end
            ST_READY: begin
                port_req = 1'b1;
                port_we  = 1'b1;
                port_adr = READY_ADR;
            end
            default: ;
        endcase
        ch_valid   = sweep_act_q;
        ch_idx     = sweep_idx_q;
        ch_rate    = sweep_act_q ? shadow_q[sweep_idx_q] : '0;
        cfg_loaded = cfg_loaded_q;
        overrun    = overrun_q;
        fault      = fault_q;
    end

    // Poll spacing, shadow loading, sweep sequencing and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q           <= '0;
            poll_wait_q   <= '0;
            sweep_act_q   <= 1'b0;
            sweep_idx_q   <= '0;
            reload_pend_q <= 1'b0;
            cfg_loaded_q  <= 1'b0;
            overrun_q     <= 1'b0;
            fault_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
        end else begin
            if (port_err) fault_q <= 1'b1;
            case (state_q)
                ST_POLL: begin
                    n_q <= '0;
                    if (poll_wait_q != '0)                 poll_wait_q <= poll_wait_q - PW'(1);
                    else if (port_done && !port_rdata[0])  poll_wait_q <= PW'(POLL_GAP);
                end
                ST_LOAD: if (port_done) begin
                    shadow_q[n_q] <= port_rdata;
                    n_q           <= n_last ? '0 : n_q + IDX_W'(1);
                end
                ST_READY: if (port_done) cfg_loaded_q <= 1'b1;
                ST_RUN: begin
                    if (reload) reload_pend_q <= 1'b1;
                    if (sweep_act_q) begin
                        if (frame_sync) overrun_q <= 1'b1;
                        if (sweep_last) begin
                            sweep_act_q <= 1'b0;
                            sweep_idx_q <= '0;
                        end else begin
                            sweep_idx_q <= sweep_idx_q + IDX_W'(1);
                        end
                    end else if (sweep_start) begin
                        sweep_act_q <= 1'b1;
                        sweep_idx_q <= '0;
                    end
                    if (go_poll) begin
                        reload_pend_q <= 1'b0;
                        cfg_loaded_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_seq_master.sv
module tb_cfg_seq_master;

    localparam int NUM_CH   = 32;
    localparam int POLL_GAP = 16;
    localparam int IDLE_GAP = 3;
    localparam int TO_CYC   = 64;
    localparam int ACK_DLY  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       reload = 1'b0;
    logic       frame_sync = 1'b0;
    logic [4:0] ch_idx;
    logic [2:0] ch_rate;
    logic       ch_valid, cfg_loaded, overrun, fault;

    cfg_seq_master_if wb ();

    cfg_seq_master dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .reload     (reload),
        .frame_sync (frame_sync),
        .wb         (wb),
        .ch_idx     (ch_idx),
        .ch_rate    (ch_rate),
        .ch_valid   (ch_valid),
        .cfg_loaded (cfg_loaded),
        .overrun    (overrun),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          done_after = 1000;
    bit          no_ack = 1'b0;
    bit          err_en = 1'b0;
    logic [15:0] err_sub = 16'h0;
    logic [2:0]  rate_tab [NUM_CH];
    int          poll_cnt = 0;
    int          wcnt = 0;
    logic        ack_q = 1'b0, err_q = 1'b0;
    logic [31:0] rdat_q = 32'h0;

    assign wb.i_wb_ack = ack_q;
    assign wb.i_wb_err = err_q;
    assign wb.i_wb_dat = rdat_q;

    always @(posedge clk) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
        if (wb.o_wb_stb && !ack_q && !err_q) begin
            if (wcnt == ACK_DLY - 1) begin
                wcnt = 0;
                if (!no_ack) begin
                    if (err_en && !wb.o_wb_we && wb.o_wb_adr[15:0] == err_sub) begin
                        err_q <= 1'b1;
                    end else begin
                        ack_q <= 1'b1;
                        if (wb.o_wb_we) rdat_q <= 32'h0;
                        else if (wb.o_wb_adr[15:0] == 16'h0080) begin
                            rdat_q <= (poll_cnt >= done_after) ? 32'h0000_0001 : 32'hFFFF_FFFE;
                            poll_cnt++;
                        end else rdat_q <= 32'hFFFF_FFF8 | {29'h0, rate_tab[wb.o_wb_adr[6:2]]};
                    end
                end
            end else wcnt = wcnt + 1;
        end else if (!wb.o_wb_stb) wcnt = 0;
    end

    // transaction log (completed transfers, pre-edge view)
    logic [31:0] log_adr [$];
    logic        log_we  [$];
    always @(posedge clk) begin
        if (wb.o_wb_stb && (wb.i_wb_ack || wb.i_wb_err)) begin
            log_adr.push_back(wb.o_wb_adr);
            log_we.push_back(wb.o_wb_we);
        end
    end

    // ---------------- behavioural model ----------------
    bit         m_loaded, m_inrun, m_pend, m_overrun, m_fault;
    int         m_beat = -1;
    int         m_to = 0;
    logic [2:0] shadow_m [NUM_CH];

    always @(posedge clk) begin : model
        bit leave;
        leave = 1'b0;
        if (reset) begin
            m_loaded = 0; m_inrun = 0; m_pend = 0; m_overrun = 0; m_fault = 0;
            m_beat = -1; m_to = 0;
            for (int i = 0; i < NUM_CH; i++) shadow_m[i] = 3'd0;
        end else begin
            if (m_inrun) begin
                if (m_beat >= 0) begin
                    if (frame_sync) m_overrun = 1;
                    if (reload) m_pend = 1;
                    if (m_beat == NUM_CH - 1) begin
                        m_beat = -1;
                        if (m_pend) leave = 1;
                    end else m_beat = m_beat + 1;
                end else if (m_pend || (reload && !frame_sync)) leave = 1;
                else if (frame_sync) begin
                    m_beat = 0;
                    if (reload) m_pend = 1;
                end
                if (leave) begin m_inrun = 0; m_loaded = 0; m_pend = 0; end
            end
            if (wb.o_wb_stb && wb.i_wb_err) m_fault = 1;
            else if (wb.o_wb_stb && wb.i_wb_ack) begin
                if (wb.o_wb_we) begin
                    if (wb.o_wb_adr[15:0] == 16'h0084) begin m_loaded = 1; m_inrun = 1; end
                end else if (wb.o_wb_adr[15:0] < 16'h0080)
                    shadow_m[wb.o_wb_adr[6:2]] = wb.i_wb_dat[2:0];
            end
`ifdef CFG_SEQ_TIMEOUT_EN
            if (wb.o_wb_stb && !wb.i_wb_ack && !wb.i_wb_err) begin
                m_to = m_to + 1;
                if (m_to == TO_CYC) m_fault = 1;
            end else m_to = 0;
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    int          cyc_n = 0;
    int          low_run = 100;
    logic        prev_stb = 1'b0;
    logic [31:0] prev_adr = 32'h0;
    logic        prev_we = 1'b0;
    int          poll_cyc [$];

    always @(negedge clk) begin
        cyc_n++;
        chk("cfg_loaded", cfg_loaded, m_loaded);
        chk("overrun", overrun, m_overrun);
        chk("fault", fault, m_fault);
        chk("ch_valid", ch_valid, m_beat >= 0);
        if (m_beat >= 0) begin
            chk("ch_idx", ch_idx, m_beat);
            chk("ch_rate", ch_rate, shadow_m[m_beat]);
        end
        chk("wb_sel", wb.o_wb_sel, wb.o_wb_stb ? 4'hF : 4'h0);
        chk("wb_cyc", wb.o_wb_cyc, wb.o_wb_stb);
        chk("wb_dat", wb.o_wb_dat, 32'h0);
        chk("wb_adr_hi", wb.o_wb_adr[31:16], 16'h0000);
        if (wb.o_wb_stb) begin
            if (!prev_stb) begin
                chk("idle_gap", low_run >= IDLE_GAP, 1);
                if (wb.o_wb_adr == 32'h80) poll_cyc.push_back(cyc_n);
            end else begin
                chk("adr_stable", wb.o_wb_adr, prev_adr);
                chk("we_stable", wb.o_wb_we, prev_we);
            end
            low_run = 0;
        end else low_run++;
        prev_stb = wb.o_wb_stb;
        prev_adr = wb.o_wb_adr;
        prev_we  = wb.o_wb_we;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_loaded(input string nm);
        int k = 0;
        while (!cfg_loaded && k < 3000) begin @(negedge clk); k++; end
        chk(nm, cfg_loaded, 1);
    endtask

    function automatic logic [2:0] exp_rate(input int mode, input int i);
        return (mode == 0) ? 3'(i % 8) : 3'((i * 3 + 1) % 8);
    endfunction

    // frame pulse followed by literal check of all beats
    task automatic sweep_check(input int mode);
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            chk("lit_valid", ch_valid, 1);
            chk("lit_idx", ch_idx, i);
            chk("lit_rate", ch_rate, exp_rate(mode, i));
            @(negedge clk);
        end
        chk("lit_after_sweep", ch_valid, 0);
    endtask

    initial begin
        int base, pbase, k, hi;
        for (int i = 0; i < NUM_CH; i++) rate_tab[i] = exp_rate(0, i);
        repeat (4) @(negedge clk);
        chk("rst_stb", wb.o_wb_stb, 0);
        chk("rst_loaded", cfg_loaded, 0);
        chk("rst_valid", ch_valid, 0);
        chk("rst_fault", fault, 0);
        reset = 1'b0;

        // bring-up: done reads 0,0,1
        done_after = poll_cnt + 2;
        base  = log_adr.size();
        pbase = poll_cyc.size();
        pulse_start();
        wait_loaded("bringup_loaded");
        chk("bringup_ntx", log_adr.size() - base, 36);
        if (log_adr.size() - base == 36) begin
            for (int i = 0; i < 36; i++) begin
                if (i < 3)       chk("done_adr", log_adr[base+i], 32'h0000_0080);
                else if (i < 35) chk("load_adr", log_adr[base+i], 32'(4 * (i - 3)));
                else             chk("ready_adr", log_adr[base+i], 32'h0000_0084);
                chk("tx_we", log_we[base+i], i == 35);
            end
        end
        chk("poll_count", poll_cyc.size() - pbase, 3);
        if (poll_cyc.size() - pbase >= 3) begin
            chk("poll_gap1", (poll_cyc[pbase+1] - poll_cyc[pbase]) >= POLL_GAP, 1);
            chk("poll_gap2", (poll_cyc[pbase+2] - poll_cyc[pbase+1]) >= POLL_GAP, 1);
        end

        // stream rate = n mod 8; start in RUN is ignored
        repeat (3) @(negedge clk);
        pulse_start();
        sweep_check(0);
        chk("no_overrun_yet", overrun, 0);

        // frame_sync at beat 10 -> overrun, sweep unchanged
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        repeat (10) @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        repeat (30) @(negedge clk);
        chk("overrun_set", overrun, 1);
        chk("overrun_sweep_done", ch_valid, 0);

        // reload mid-sweep with new rates
        for (int i = 0; i < NUM_CH; i++) rate_tab[i] = exp_rate(1, i);
        done_after = poll_cnt;
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        repeat (5) @(negedge clk);
        reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        k = 0;
        while (ch_valid && k < 40) begin
            chk("loaded_during_sweep", cfg_loaded, 1);
            @(negedge clk); k++;
        end
        chk("loaded_drop", cfg_loaded, 0);
        wait_loaded("reload_loaded");
        chk("overrun_sticky", overrun, 1);
        repeat (2) @(negedge clk);
        sweep_check(1);

        // bus error on LOAD n = 5
        err_en = 1'b1; err_sub = 16'h0014; done_after = poll_cnt;
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        k = 0;
        while (!fault && k < 2000) begin @(negedge clk); k++; end
        chk("err_fault", fault, 1);
        chk("err_stb_low", wb.o_wb_stb, 0);
        chk("err_adr", log_adr[log_adr.size()-1], 32'h0000_0014);
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
        hi = 0;
        repeat (40) begin if (ch_valid || wb.o_wb_stb) hi++; @(negedge clk); end
        chk("halt_silent", hi, 0);
        chk("halt_fault", fault, 1);

        // slave never acks
        err_en = 1'b0; no_ack = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst2_fault", fault, 0);
        pulse_start();
        k = 0;
        while (!wb.o_wb_stb && k < 200) begin @(negedge clk); k++; end
        chk("noack_stb_rise", wb.o_wb_stb, 1);
        hi = 0;
        repeat (100) begin if (wb.o_wb_stb) hi++; @(negedge clk); end
`ifdef CFG_SEQ_TIMEOUT_EN
        chk("timeout_len", hi, TO_CYC);
        chk("timeout_fault", fault, 1);
        chk("timeout_stb", wb.o_wb_stb, 0);
`else
        chk("noack_len", hi, 100);
        chk("noack_fault", fault, 0);
        chk("noack_stb", wb.o_wb_stb, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
